// File: rtl/cla_result_stage.sv
// cla_result_stage: CLA result flags into a 2-entry valid/ready FIFO plus saturating overflow count; CLA_RESULT_PARITY_EN adds a parity output
module cla_result_stage #(
  parameter int Bit = 8,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Bit-1:0]       P,
  input  logic [Bit:0]         C,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Bit-1:0]       sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero,
`ifdef CLA_RESULT_PARITY_EN
  output logic                 parity,
`endif
  output logic [OVF_CNT_W-1:0] ovf_cnt
);
`ifdef CLA_RESULT_PARITY_EN
  localparam int EW = Bit + 4;
`else
  localparam int EW = Bit + 3;
`endif
  logic [Bit-1:0] s;
  logic [EW-1:0] e, head;
  logic [EW-1:0] mem [2];
  logic wp, rp, push, pop;
  logic [1:0] count;
  assign s = P ^ C[Bit-1:0];
`ifdef CLA_RESULT_PARITY_EN
  assign e = {^s, s == '0, C[Bit] ^ C[Bit-1], C[Bit], s};
  assign parity = head[Bit+3];
`else
  assign e = {s == '0, C[Bit] ^ C[Bit-1], C[Bit], s};
`endif
  assign in_ready = (count != 2'd2) & ~rst;
  assign out_valid = count != 2'd0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign head = mem[rp];
  assign {zero, ovf, cout, sum} = head[Bit+2:0];
  // FIFO storage, pointers, occupancy and saturating overflow counter; entries zeroed on reset so outputs read 0
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
      ovf_cnt <= '0;
    end else begin
      if (push) mem[wp] <= e;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push & e[Bit+1] & ~&ovf_cnt) ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cla_result_stage.sv
// tb_cla_result_stage: randomized and directed checks of cla_result_stage against an arithmetic queue model
module tb_cla_result_stage;
  localparam int Bit = 8;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [Bit-1:0] P = '0;
  logic [Bit:0] C = '0;
  logic in_ready, out_valid, cout, ovf, zero;
  logic [Bit-1:0] sum;
  logic [7:0] ovf_cnt;
  logic in_ready2, out_valid2, cout2, ovf2, zero2;
  logic [Bit-1:0] sum2;
  logic [1:0] ovf_cnt2;
`ifdef CLA_RESULT_PARITY_EN
  logic parity, parity2;
`endif
  always #5 clk = ~clk;
  cla_result_stage #(.Bit(Bit), .OVF_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .P(P), .C(C),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero),
`ifdef CLA_RESULT_PARITY_EN
    .parity(parity),
`endif
    .ovf_cnt(ovf_cnt));
  cla_result_stage #(.Bit(Bit), .OVF_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .P(P), .C(C),
    .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2),
`ifdef CLA_RESULT_PARITY_EN
    .parity(parity2),
`endif
    .ovf_cnt(ovf_cnt2));
  wire [Bit+2:0] head = {zero, ovf, cout, sum};
  logic [Bit+2:0] q[$];
  logic [Bit+2:0] exp_in;
  int c8 = 0, c2 = 0, total = 0, bad = 0;
  task automatic drive_ab(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] s9;
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    s9 = 9'(a) + 9'(b) + 9'(cin);
    P = a ^ b;
    for (int i = 0; i <= Bit; i++) C[i] = 1'(((ai & ((1 << i) - 1)) + (bi & ((1 << i) - 1)) + int'(cin)) >> i);
    exp_in = {s9[7:0] == 8'd0, (a[7] == b[7]) && (s9[7] != a[7]), s9[8], s9[7:0]};
    in_valid = 1;
  endtask
  task automatic drive_pc(input logic [7:0] p, input logic [8:0] c, input logic [10:0] e);
    P = p;
    C = c;
    exp_in = e;
    in_valid = 1;
  endtask
  task automatic tick();
    bit mpush, mpop;
    mpush = in_valid && !rst && q.size() < 2;
    mpop = out_ready && q.size() != 0;
    @(posedge clk);
    if (rst) begin
      q.delete();
      c8 = 0;
      c2 = 0;
    end else begin
      if (mpop) void'(q.pop_front());
      if (mpush) begin
        q.push_back(exp_in);
        if (exp_in[Bit+1]) begin
          if (c8 < 255) c8++;
          if (c2 < 3) c2++;
        end
      end
    end
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    drive_ab(8'h12, 8'h34, 1'b0);
    tick();
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    rst = 0;
    in_valid = 0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b exp=0", out_valid); end
    total++; if (head !== '0) begin bad++; $display("FAIL post_rst_fields got=%h exp=0", head); end
    total++; if (ovf_cnt !== 8'd0) begin bad++; $display("FAIL post_rst_ovf_cnt got=%0d exp=0", ovf_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
  endtask
  task automatic test_directed();
    logic [7:0] pv [4] = '{8'h66, 8'h00, 8'h7E, 8'h00};
    logic [8:0] cv [4] = '{9'h01E, 9'h1FF, 9'h0FE, 9'h000};
    logic [10:0] ev [4] = '{{3'b000, 8'h78}, {3'b001, 8'hFF}, {3'b010, 8'h80}, {3'b100, 8'h00}};
    int oc [4] = '{0, 0, 1, 1};
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      drive_pc(pv[k], cv[k], ev[k]);
      tick();
      in_valid = 0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_valid got=%b exp=1", k, out_valid); end
      total++; if (head !== ev[k]) begin bad++; $display("FAIL dir%0d_fields got=%h exp=%h", k, head, ev[k]); end
      total++; if (ovf_cnt !== 8'(oc[k])) begin bad++; $display("FAIL dir%0d_ovf_cnt got=%0d exp=%0d", k, ovf_cnt, oc[k]); end
      tick();
    end
  endtask
  task automatic test_backpressure();
    logic [10:0] e [3];
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      drive_ab(8'($urandom), 8'($urandom), 1'($urandom));
      e[k] = exp_in;
      total++; if (in_ready !== (k < 2)) begin bad++; $display("FAIL bp_in_ready%0d got=%b exp=%b", k, in_ready, k < 2); end
      tick();
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      total++; if (head !== e[0] || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", k, head, e[0]); end
      tick();
    end
    out_ready = 1;
    total++; if (head !== e[0]) begin bad++; $display("FAIL bp_first got=%h exp=%h", head, e[0]); end
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    total++; if (head !== e[1] || out_valid !== 1'b1) begin bad++; $display("FAIL bp_second got=%h exp=%h", head, e[1]); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask
  task automatic test_back_to_back();
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      drive_ab(8'($urandom), 8'($urandom), 1'($urandom));
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready%0d got=%b exp=1", i, in_ready); end
      if (i > 0) begin
        total++; if (out_valid !== 1'b1 || head !== q[0]) begin bad++; $display("FAIL b2b_head%0d got=%b/%h exp=1/%h", i, out_valid, head, q[0]); end
      end
      tick();
    end
    in_valid = 0;
    tick();
  endtask
  task automatic test_reset_mid();
    out_ready = 0;
    drive_ab(8'h7F, 8'h01, 1'b0);
    tick();
    drive_ab(8'hA5, 8'h5A, 1'b1);
    tick();
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid%0d got=%b exp=0", k, out_valid); end
      total++; if (head !== '0 || ovf_cnt !== 8'd0) begin bad++; $display("FAIL rmid_state%0d got=%h/%0d exp=0/0", k, head, ovf_cnt); end
      tick();
    end
  endtask
  task automatic test_saturation();
    out_ready = 1;
    for (int k = 1; k <= 5; k++) begin
      drive_ab(8'h7F, 8'h01, 1'b0);
      tick();
      total++; if (ovf_cnt2 !== 2'(c2) || ovf_cnt !== 8'(c8)) begin bad++; $display("FAIL sat%0d got=%0d/%0d exp=%0d/%0d", k, ovf_cnt2, ovf_cnt, c2, c8); end
    end
    in_valid = 0;
    tick();
    total++; if (ovf_cnt2 !== 2'd3 || ovf_cnt !== 8'd5) begin bad++; $display("FAIL sat_final got=%0d/%0d exp=3/5", ovf_cnt2, ovf_cnt); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_ab(8'($urandom), 8'($urandom), 1'($urandom));
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_in_ready%0d got=%b exp=%b", i, in_ready, q.size() < 2); end
      total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid%0d got=%b exp=%b", i, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        total++; if (head !== q[0]) begin bad++; $display("FAIL rnd_head%0d got=%h exp=%h", i, head, q[0]); end
`ifdef CLA_RESULT_PARITY_EN
        total++; if (parity !== ^q[0][7:0]) begin bad++; $display("FAIL rnd_parity%0d got=%b exp=%b", i, parity, ^q[0][7:0]); end
`endif
      end
      total++; if (ovf_cnt !== 8'(c8) || ovf_cnt2 !== 2'(c2)) begin bad++; $display("FAIL rnd_ovf_cnt%0d got=%0d/%0d exp=%0d/%0d", i, ovf_cnt, ovf_cnt2, c8, c2); end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
